ifetch_unit: RTL and testbench

Instruction fetch unit that owns the architectural PC register and is the consumer of the next-PC value produced by the next-PC logic. It issues word reads to instruction memory over a req/ack handshake, holds the returned instruction for the decode/execute stage under a valid/ready handshake, and loads the supplied next PC when that instruction is accepted. It also flags misaligned next PCs and keeps a wrapping count of accepted instructions.

---
 rtl/ifetch_unit.sv | 111 +++++++++++
 tb/tb_ifetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake and
// presents each instruction to decode under valid/ready, loading npc on accept.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_npc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc4,
  output logic        o_addr_err,
  output logic [31:0] o_inst_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StErr
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_nxt;
  logic        r_addr_err;
  logic        w_addr_err_nxt;
  logic [31:0] r_inst_cnt;
  logic [31:0] w_inst_cnt_nxt;

  // Reset wins over any ack or accept seen on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      r_addr_err <= 1'b0;
      r_inst_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_addr_err <= w_addr_err_nxt;
      r_inst_cnt <= w_inst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_addr_err_nxt = r_addr_err;
    w_inst_cnt_nxt = r_inst_cnt;

    unique case (r_state)
      StIdle: begin
        w_state_nxt = StFetch;
      end
      StFetch: begin
        if (i_imem_ack) begin
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = i_imem_rdata;
          w_state_nxt    = StHold;
        end
      end
      StHold: begin
        if (i_if_ready) begin
          w_inst_cnt_nxt = r_inst_cnt + 32'd1;
          // A misaligned target is still loaded so it can be inspected after the trap.
          w_pc_nxt       = i_npc;
          if (i_npc[1:0] != 2'b00) begin
            w_addr_err_nxt = 1'b1;
            w_state_nxt    = StErr;
          end else begin
            w_state_nxt    = StFetch;
          end
        end
      end
      StErr: begin
        w_state_nxt = StErr;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_imem_req  = (r_state == StFetch);
  assign o_imem_addr = r_pc;
  assign o_if_valid  = (r_state == StHold);
  assign o_if_pc     = r_if_pc;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc4    = r_if_pc + 32'd4;
  assign o_addr_err  = r_addr_err;
  assign o_inst_cnt  = r_inst_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, zero-wait/wrap sequences, and a
// randomized run against a transaction-rule reference model.
module tb_ifetch_unit;

  logic        clk;
  logic        tb_rst;
  logic [31:0] tb_npc;
  logic        tb_ack;
  logic [31:0] tb_rdata;
  logic        tb_rdy;
  logic        tie;

  logic        w_rst_n;
  logic [31:0] w_npc;
  logic        w_ack;
  logic [31:0] w_rdata;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc4;
  logic        o_addr_err;
  logic [31:0] o_inst_cnt;

  int n_chk;
  int n_pass;

  // In tied mode the memory acks every request at once and npc follows if_pc4.
  assign w_rst_n = tb_rst;
  assign w_ack   = tie ? o_imem_req : tb_ack;
  assign w_rdata = tie ? (o_imem_addr ^ 32'h5A5A_0000) : tb_rdata;
  assign w_npc   = tie ? o_if_pc4 : tb_npc;

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .i_clk        (clk),
    .i_rst_n      (w_rst_n),
    .i_npc        (w_npc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (w_ack),
    .i_imem_rdata (w_rdata),
    .o_if_valid   (o_if_valid),
    .i_if_ready   (tb_rdy),
    .o_if_pc      (o_if_pc),
    .o_if_instr   (o_if_instr),
    .o_if_pc4     (o_if_pc4),
    .o_addr_err   (o_addr_err),
    .o_inst_cnt   (o_inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic ack, logic [31:0] rdata, logic rdy,
                             logic [31:0] npc, logic req, logic [31:0] addr, logic vld,
                             logic [31:0] ifpc, logic [31:0] instr, logic err,
                             logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.ack = ack; r.rdata = rdata; r.rdy = rdy; r.npc = npc;
    r.req = req; r.addr = addr; r.vld = vld; r.ifpc = ifpc; r.instr = instr;
    r.err = err; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: spec rules applied once per edge.
  logic        m_fetch, m_hold, m_dead;
  logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
  logic        m_err;

  task automatic model_step();
    if (!tb_rst) begin
      m_fetch = 1'b0; m_hold = 1'b0; m_dead = 1'b0;
      m_pc = 32'h0000_3000; m_ifpc = '0; m_instr = '0; m_cnt = '0; m_err = 1'b0;
    end else if (m_dead) begin
      // stuck until reset
    end else if (m_hold) begin
      if (tb_rdy) begin
        m_cnt  = m_cnt + 32'd1;
        m_pc   = tb_npc;
        m_hold = 1'b0;
        if (tb_npc % 4 != 0) begin
          m_err  = 1'b1;
          m_dead = 1'b1;
        end else begin
          m_fetch = 1'b1;
        end
      end
    end else if (m_fetch) begin
      if (tb_ack) begin
        m_ifpc  = m_pc;
        m_instr = tb_rdata;
        m_fetch = 1'b0;
        m_hold  = 1'b1;
      end
    end else begin
      m_fetch = 1'b1;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    tie = 1'b0; tb_rst = 1'b0; tb_ack = 1'b0; tb_rdata = '0; tb_rdy = 1'b0; tb_npc = '0;

    // rst ack rdata rdy npc | req addr vld ifpc instr err cnt
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 32'h1111_1111, 0, 0, 0, 32'h3000, 1, 32'h3000, 32'h1111_1111, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 32'h3004, 1, 32'h3004, 0, 32'h3000, 32'h1111_1111, 0, 1));
    tbl.push_back(v(1, 1, 32'h2222_2222, 0, 0, 0, 32'h3004, 1, 32'h3004, 32'h2222_2222, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 32'h3008, 1, 32'h3008, 0, 32'h3004, 32'h2222_2222, 0, 2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 32'h3008, 0, 32'h3004, 32'h2222_2222, 0, 2));
    tbl.push_back(v(1, 1, 32'h2402_0005, 0, 0, 0, 32'h3008, 1, 32'h3008, 32'h2402_0005, 0, 2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1, 1, 32'h5555_5555, 0, 32'h3040, 0, 32'h3008, 1, 32'h3008,
                      32'h2402_0005, 0, 2));
    tbl.push_back(v(1, 0, 0, 1, 32'h3040, 1, 32'h3040, 0, 32'h3008, 32'h2402_0005, 0, 3));
    tbl.push_back(v(1, 1, 32'h3333_3333, 0, 0, 0, 32'h3040, 1, 32'h3040, 32'h3333_3333, 0, 3));
    tbl.push_back(v(1, 0, 0, 1, 32'h3042, 0, 32'h3042, 0, 32'h3040, 32'h3333_3333, 1, 4));
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(1, 1, 32'h4444_4444, 1, 32'h3000, 0, 32'h3042, 0, 32'h3040,
                      32'h3333_3333, 1, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h6666_6666, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 32'h0102_0304, 0, 0, 0, 32'h3000, 1, 32'h3000, 32'h0102_0304, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h3000, 32'h0102_0304,
                    0, 1));
    tbl.push_back(v(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,
                    32'hDEAD_BEEF, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 32'h0, 1, 32'h0, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 2));

    foreach (tbl[i]) begin
      tb_rst = tbl[i].rst; tb_ack = tbl[i].ack; tb_rdata = tbl[i].rdata;
      tb_rdy = tbl[i].rdy; tb_npc = tbl[i].npc;
      step();
      chk($sformatf("v%0d.req", i), 32'(o_imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d.addr", i), o_imem_addr, tbl[i].addr);
      chk($sformatf("v%0d.valid", i), 32'(o_if_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d.if_pc", i), o_if_pc, tbl[i].ifpc);
      chk($sformatf("v%0d.if_instr", i), o_if_instr, tbl[i].instr);
      chk($sformatf("v%0d.if_pc4", i), o_if_pc4, tbl[i].ifpc + 32'd4);
      chk($sformatf("v%0d.addr_err", i), 32'(o_addr_err), 32'(tbl[i].err));
      chk($sformatf("v%0d.inst_cnt", i), o_inst_cnt, tbl[i].cnt);
    end

    // Zero-wait memory, always ready, sequential npc.
    tie = 1'b1; tb_rdy = 1'b1; tb_rst = 1'b0;
    step();
    chk("zw.rst_req", 32'(o_imem_req), 32'd0);
    chk("zw.rst_pc4", o_if_pc4, 32'd4);
    tb_rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c % 2 == 1) begin
        chk($sformatf("zw%0d.req", c), 32'(o_imem_req), 32'd1);
        chk($sformatf("zw%0d.addr", c), o_imem_addr, 32'h3000 + 32'(2 * (c - 1)));
        chk($sformatf("zw%0d.cnt", c), o_inst_cnt, 32'((c - 1) / 2));
      end else begin
        chk($sformatf("zw%0d.valid", c), 32'(o_if_valid), 32'd1);
        chk($sformatf("zw%0d.if_pc", c), o_if_pc, 32'h3000 + 32'(2 * (c - 2)));
        chk($sformatf("zw%0d.if_pc4", c), o_if_pc4, 32'h3004 + 32'(2 * (c - 2)));
        chk($sformatf("zw%0d.instr", c), o_if_instr,
            (32'h3000 + 32'(2 * (c - 2))) ^ 32'h5A5A_0000);
      end
    end

    // Counter wrap: preload all-ones while holding, then one accept.
    force dut.r_inst_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_inst_cnt;
    chk("wrap.pre", o_inst_cnt, 32'hFFFF_FFFF);
    step();
    chk("wrap.cnt", o_inst_cnt, 32'd0);
    chk("wrap.addr", o_imem_addr, 32'h3010);
    tie = 1'b0;

    // Randomized run against the model.
    for (int n = 0; n < 800; n++) begin
      int r;
      tb_rst   = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      tb_ack   = ($urandom_range(0, 2) == 0);
      tb_rdata = $urandom;
      tb_rdy   = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 99);
      if (r < 4)       tb_npc = $urandom | 32'h1;
      else if (r < 55) tb_npc = m_ifpc + 32'd4;
      else             tb_npc = $urandom & 32'hFFFF_FFFC;
      model_step();
      step();
      chk("rnd.req", 32'(o_imem_req), 32'(m_fetch));
      chk("rnd.addr", o_imem_addr, m_pc);
      chk("rnd.valid", 32'(o_if_valid), 32'(m_hold));
      chk("rnd.if_pc", o_if_pc, m_ifpc);
      chk("rnd.if_instr", o_if_instr, m_instr);
      chk("rnd.if_pc4", o_if_pc4, m_ifpc + 32'd4);
      chk("rnd.addr_err", 32'(o_addr_err), 32'(m_err));
      chk("rnd.inst_cnt", o_inst_cnt, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
